// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the camera I2C control slice: arbiter FSM states
// and transaction format constants.
package i2c_ctrl_pkg;

    localparam int         I2C_XFER_W     = 24;
    localparam logic [7:0] CAM_SLAVE_ADDR = 8'hBA;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CHECK     = 3'd4,
        ST_GAP_WAIT  = 3'd5
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching circularly
// from rr_ptr, returned both one-hot and as an index.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand_s;

    // Circular priority search starting at rr_ptr
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        cand_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, rr_ptr} + CW'(i);
            if (cand_s >= CW'(N_REQ)) begin
                cand_s = cand_s - CW'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_valid && req[cand_s[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_s[IDX_W-1:0];
            end else begin
                gnt_valid = gnt_valid;
            end
        end
        gnt_onehot[gnt_idx] = gnt_valid;
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one 24-bit I2C write engine among N_REQ
// requesters, with GO/END/ACK handshake, timeout and bounded retry.
module i2c_req_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 2000000,
    parameter int GAP       = 1000
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic [N_REQ-1:0]            iREQ,
    input  logic [I2C_XFER_W*N_REQ-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]            oGNT,
    output logic [N_REQ-1:0]            oDONE,
    output logic [N_REQ-1:0]            oERR,
    output logic [I2C_XFER_W-1:0]       oI2C_DATA,
    output logic                        oI2C_GO,
    input  logic                        iI2C_END,
    input  logic                        iI2C_ACK,
    output logic                        oBUSY
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_t             state_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       win_idx_r;
    logic [RC_W-1:0]        retry_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic [GAP_W-1:0]       gap_cnt_r;
    logic                   timed_out_r;
    logic                   release_r;
    logic [N_REQ-1:0]       gnt_r;
    logic [N_REQ-1:0]       done_r;
    logic [N_REQ-1:0]       err_r;
    logic [I2C_XFER_W-1:0]  data_r;
    logic                   go_r;

    logic [N_REQ-1:0]       pick_onehot_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_valid_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (iREQ),
        .rr_ptr     (rr_ptr_r),
        .gnt_onehot (pick_onehot_s),
        .gnt_idx    (pick_idx_s),
        .gnt_valid  (pick_valid_s)
    );

    // Arbitration and engine handshake FSM; all outputs registered here
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            win_idx_r   <= '0;
            retry_cnt_r <= '0;
            to_cnt_r    <= '0;
            gap_cnt_r   <= '0;
            timed_out_r <= 1'b0;
            release_r   <= 1'b0;
            gnt_r       <= '0;
            done_r      <= '0;
            err_r       <= '0;
            data_r      <= '0;
            go_r        <= 1'b0;
        end else begin
            done_r <= '0;
            err_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r       <= pick_onehot_s;
                        win_idx_r   <= pick_idx_s;
                        data_r      <= iREQ_DATA[pick_idx_s*I2C_XFER_W +: I2C_XFER_W];
                        rr_ptr_r    <= (pick_idx_s == IDX_LAST) ? '0 : pick_idx_s + 1'b1;
                        retry_cnt_r <= '0;
                        state_r     <= ST_START;
                    end
                end
                ST_START: begin
                    go_r        <= 1'b1;
                    to_cnt_r    <= '0;
                    timed_out_r <= 1'b0;
                    state_r     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (to_cnt_r == TO_LAST) begin
                        timed_out_r <= 1'b1;
                        state_r     <= ST_CHECK;
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                        if (!iI2C_END) begin
                            state_r <= ST_WAIT_DONE;
                        end
                    end
                end
                // END is only accepted here, after busy was observed
                ST_WAIT_DONE: begin
                    if (to_cnt_r == TO_LAST) begin
                        timed_out_r <= 1'b1;
                        state_r     <= ST_CHECK;
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                        if (iI2C_END) begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    go_r      <= 1'b0;
                    gap_cnt_r <= '0;
                    state_r   <= ST_GAP_WAIT;
                    if (!iI2C_ACK && !timed_out_r) begin
                        done_r[win_idx_r] <= 1'b1;
                        release_r         <= 1'b1;
                    end else if (retry_cnt_r < RC_MAX) begin
                        retry_cnt_r <= retry_cnt_r + 1'b1;
                        release_r   <= 1'b0;
                    end else begin
                        err_r[win_idx_r] <= 1'b1;
                        release_r        <= 1'b1;
                    end
                end
                ST_GAP_WAIT: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        if (release_r) begin
                            gnt_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_START;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                default: begin
                    go_r    <= 1'b0;
                    gnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign oGNT      = gnt_r;
    assign oDONE     = done_r;
    assign oERR      = err_r;
    assign oI2C_DATA = data_r;
    assign oI2C_GO   = go_r;
    assign oBUSY     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed-vector bench for i2c_req_arbiter with a simple engine model and
// short TIMEOUT/GAP values.
module tb_i2c_req_arbiter;

    localparam int N_REQ     = 2;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 40;
    localparam int GAP       = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [1:0]  iREQ = 2'b00;
    logic [47:0] iREQ_DATA = 48'h0;
    logic [1:0]  oGNT;
    logic [1:0]  oDONE;
    logic [1:0]  oERR;
    logic [23:0] oI2C_DATA;
    logic        oI2C_GO;
    logic        iI2C_END = 1'b1;
    logic        iI2C_ACK = 1'b0;
    logic        oBUSY;

    i2c_req_arbiter #(
        .N_REQ     (N_REQ),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT),
        .GAP       (GAP)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iREQ      (iREQ),
        .iREQ_DATA (iREQ_DATA),
        .oGNT      (oGNT),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (iI2C_END),
        .iI2C_ACK  (iI2C_ACK),
        .oBUSY     (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_err = 0;

    // GO edge / run-length and pulse accounting, sampled on the falling edge
    logic go_prev = 1'b0;
    int   go_rises = 0;
    int   high_run = 0;
    int   low_run = 0;
    int   high_len_last = 0;
    int   low_len_last = 0;
    int   done_cnt [2] = '{0, 0};
    int   err_cnt  [2] = '{0, 0};

    always @(negedge iCLK) begin
        go_prev <= oI2C_GO;
        if (oI2C_GO && !go_prev) begin
            go_rises     <= go_rises + 1;
            low_len_last <= low_run;
            high_run     <= 1;
        end else if (oI2C_GO) begin
            high_run <= high_run + 1;
        end
        if (!oI2C_GO && go_prev) begin
            high_len_last <= high_run;
            low_run       <= 1;
        end else if (!oI2C_GO) begin
            low_run <= low_run + 1;
        end
        done_cnt[0] <= done_cnt[0] + int'(oDONE[0]);
        done_cnt[1] <= done_cnt[1] + int'(oDONE[1]);
        err_cnt[0]  <= err_cnt[0] + int'(oERR[0]);
        err_cnt[1]  <= err_cnt[1] + int'(oERR[1]);
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    // Engine model: wait for GO, optionally go busy then report ACK, wait for GO drop
    task automatic engine(input int busy, input logic ack, input logic hang,
                          output logic [1:0] gnt_o, output logic [23:0] data_o);
        int t;
        t = 0;
        tick();
        while (!oI2C_GO && t < 300) begin
            tick();
            t++;
        end
        check_vec("go_rise", 32'(oI2C_GO), 32'h1);
        gnt_o  = oGNT;
        data_o = oI2C_DATA;
        if (!hang) begin
            iI2C_END = 1'b0;
            repeat (busy) tick();
            iI2C_END = 1'b1;
            iI2C_ACK = ack;
        end
        t = 0;
        while (oI2C_GO && t < 300) begin
            tick();
            t++;
        end
        check_vec("go_fall", 32'(oI2C_GO), 32'h0);
        iI2C_ACK = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (oBUSY && cycles < 200) begin
            tick();
            cycles++;
        end
        check_vec("idle", 32'(oBUSY), 32'h0);
    endtask

    logic [1:0]  g;
    logic [23:0] d;
    int          cyc;
    int          b_rise, b_done0, b_done1, b_err0, b_err1;

    task automatic snap();
        b_rise  = go_rises;
        b_done0 = done_cnt[0];
        b_done1 = done_cnt[1];
        b_err0  = err_cnt[0];
        b_err1  = err_cnt[1];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_vec("rst_gnt", 32'(oGNT), 32'h0);
        check_vec("rst_done", 32'(oDONE), 32'h0);
        check_vec("rst_err", 32'(oERR), 32'h0);
        check_vec("rst_data", 32'(oI2C_DATA), 32'h0);
        check_vec("rst_go", 32'(oI2C_GO), 32'h0);
        check_vec("rst_busy", 32'(oBUSY), 32'h0);
        iRST = 1'b0;
        tick();

        // Contention from reset: 0 then 1
        iREQ_DATA = {24'hBA1100, 24'hBA1000};
        iREQ = 2'b11;
        engine(5, 1'b0, 1'b0, g, d);
        check_vec("cont_gnt0", 32'(g), 32'h1);
        check_vec("cont_data0", 32'(d), 32'hBA1000);
        iREQ[0] = 1'b0;
        engine(5, 1'b0, 1'b0, g, d);
        check_vec("cont_gnt1", 32'(g), 32'h2);
        check_vec("cont_data1", 32'(d), 32'hBA1100);
        iREQ[1] = 1'b0;
        wait_idle(cyc);
        check_vec("cont_done0", 32'(done_cnt[0]), 32'h1);
        check_vec("cont_done1", 32'(done_cnt[1]), 32'h1);

        // Single request, 5-cycle busy, ACK ok
        iREQ_DATA[23:0] = 24'hBA2000;
        iREQ = 2'b01;
        engine(5, 1'b0, 1'b0, g, d);
        check_vec("single_gnt", 32'(g), 32'h1);
        check_vec("single_data", 32'(d), 32'hBA2000);
        check_vec("single_go_len", 32'(high_len_last), 32'd7);
        iREQ = 2'b00;
        wait_idle(cyc);
        check_vec("single_gap", 32'(cyc), 32'(GAP));
        check_vec("single_done", 32'(done_cnt[0]), 32'h2);
        check_vec("single_err", 32'(err_cnt[0] + err_cnt[1]), 32'h0);

        // Rotation: pointer now at 1, so 1 then 0
        iREQ = 2'b11;
        engine(3, 1'b0, 1'b0, g, d);
        check_vec("rot_gnt1", 32'(g), 32'h2);
        iREQ[1] = 1'b0;
        engine(3, 1'b0, 1'b0, g, d);
        check_vec("rot_gnt0", 32'(g), 32'h1);
        iREQ[0] = 1'b0;
        wait_idle(cyc);

        // NACK twice then ACK; late data change ignored
        snap();
        iREQ_DATA[23:0] = 24'hBA3355;
        iREQ = 2'b01;
        engine(4, 1'b1, 1'b0, g, d);
        check_vec("nack_data1", 32'(d), 32'hBA3355);
        iREQ_DATA[23:0] = 24'h123456;
        engine(4, 1'b1, 1'b0, g, d);
        check_vec("nack_data2", 32'(d), 32'hBA3355);
        check_vec("nack_gnt2", 32'(g), 32'h1);
        check_vec("nack_gap2", 32'(low_len_last >= GAP), 32'h1);
        engine(4, 1'b0, 1'b0, g, d);
        check_vec("nack_data3", 32'(d), 32'hBA3355);
        check_vec("nack_gap3", 32'(low_len_last >= GAP), 32'h1);
        iREQ = 2'b00;
        wait_idle(cyc);
        check_vec("nack_rises", 32'(go_rises - b_rise), 32'd3);
        check_vec("nack_done", 32'(done_cnt[0] - b_done0), 32'd1);
        check_vec("nack_err", 32'(err_cnt[0] - b_err0), 32'd0);

        // Retry exhaustion, requester 1 waiting
        snap();
        iREQ_DATA = {24'hBA4111, 24'hBA4000};
        iREQ = 2'b01;
        engine(3, 1'b1, 1'b0, g, d);
        check_vec("exh_gnt", 32'(g), 32'h1);
        iREQ[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            engine(3, 1'b1, 1'b0, g, d);
            check_vec("exh_gnt_hold", 32'(g), 32'h1);
        end
        iREQ[0] = 1'b0;
        check_vec("exh_err", 32'(err_cnt[0] - b_err0), 32'd1);
        check_vec("exh_done", 32'(done_cnt[0] - b_done0), 32'd0);
        check_vec("exh_rises", 32'(go_rises - b_rise), 32'd4);
        engine(3, 1'b0, 1'b0, g, d);
        check_vec("exh_next_gnt", 32'(g), 32'h2);
        check_vec("exh_next_data", 32'(d), 32'hBA4111);
        iREQ[1] = 1'b0;
        wait_idle(cyc);
        check_vec("exh_next_done", 32'(done_cnt[1] - b_done1), 32'd1);

        // Timeout: END never drops
        snap();
        iREQ_DATA[23:0] = 24'hBA5000;
        iREQ = 2'b01;
        for (int i = 0; i < 4; i++) begin
            engine(0, 1'b0, 1'b1, g, d);
            check_vec("to_gnt", 32'(g), 32'h1);
            check_vec("to_len", 32'(high_len_last >= TIMEOUT && high_len_last <= TIMEOUT + 1), 32'h1);
        end
        iREQ = 2'b00;
        wait_idle(cyc);
        check_vec("to_rises", 32'(go_rises - b_rise), 32'd4);
        check_vec("to_err", 32'(err_cnt[0] - b_err0), 32'd1);
        check_vec("to_done", 32'(done_cnt[0] - b_done0), 32'd0);

        // Reset during WAIT_DONE (pointer is 1 after this grant)
        iREQ = 2'b01;
        cyc = 0;
        tick();
        while (!oI2C_GO && cyc < 300) begin
            tick();
            cyc++;
        end
        iI2C_END = 1'b0;
        tick();
        tick();
        snap();
        iRST = 1'b1;
        #1;
        check_vec("mrst_go", 32'(oI2C_GO), 32'h0);
        check_vec("mrst_gnt", 32'(oGNT), 32'h0);
        check_vec("mrst_busy", 32'(oBUSY), 32'h0);
        iREQ = 2'b00;
        iI2C_END = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        tick();
        tick();
        check_vec("mrst_done", 32'(done_cnt[0] + done_cnt[1] - b_done0 - b_done1), 32'd0);
        check_vec("mrst_err", 32'(err_cnt[0] + err_cnt[1] - b_err0 - b_err1), 32'd0);
        iREQ = 2'b11;
        engine(3, 1'b0, 1'b0, g, d);
        check_vec("mrst_regnt0", 32'(g), 32'h1);
        iREQ[0] = 1'b0;
        engine(3, 1'b0, 1'b0, g, d);
        check_vec("mrst_regnt1", 32'(g), 32'h2);
        iREQ[1] = 1'b0;
        wait_idle(cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
